// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD string refresher: HD44780 command bytes,
// the main sequencer state encoding, the bus-writer phase encoding and the
// power-on init command table.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
  localparam logic [7:0] LCD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;
  localparam logic [7:0] LCD_LINE1        = 8'h80;
  localparam logic [7:0] LCD_LINE2        = 8'hC0;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2,
    ST_IDLE
  } main_state_e;

  typedef enum logic [1:0] {
    BW_IDLE,
    BW_SETUP,
    BW_EN,
    BW_WAIT
  } bw_phase_e;

  // Init commands in the order the panel expects them.
  function automatic logic [7:0] init_cmd(input logic [1:0] sel);
    logic [7:0] cmd;
    case (sel)
      2'd0:    cmd = LCD_FUNC_8BIT_2L;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_CLEAR;
      default: cmd = LCD_ENTRY_INC;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// Single LCD bus transfer: one setup cycle, EN_CYC cycles of EN high, then a
// post-transfer wait (CLR_CYC when long_wait, else WAIT_CYC). done is high in
// the last wait cycle; a start seen in that cycle launches the next setup on
// the following cycle, so transfers can run back to back.
// Ports: iCLK/iRST_N clock and async active-low reset; start/rs/data/long_wait
// request a transfer; done marks its end; lcd_data/lcd_rs/lcd_en drive pins.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned EN_CYC   = 25,
  parameter int unsigned WAIT_CYC = 2000,
  parameter int unsigned CLR_CYC  = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int unsigned MAX_AB = (EN_CYC > WAIT_CYC) ? EN_CYC : WAIT_CYC;
  localparam int unsigned MAX_C  = (MAX_AB > CLR_CYC) ? MAX_AB : CLR_CYC;
  localparam int CW = $clog2(MAX_C + 1);

  bw_phase_e     phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          long_q, long_d;
  logic          en_q, en_d;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      phase_q <= BW_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;
    en_d    = en_q;
    done    = 1'b0;
    case (phase_q)
      BW_SETUP: begin
        phase_d = BW_EN;
        cnt_d   = CW'(EN_CYC - 1);
        en_d    = 1'b1;
      end
      BW_EN: begin
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          phase_d = BW_WAIT;
          cnt_d   = long_q ? CW'(CLR_CYC - 1) : CW'(WAIT_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BW_WAIT: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          phase_d = BW_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
    // Data/RS only change when a new transfer is accepted, so they stay
    // stable from setup through the end of the wait.
    if (start && (phase_q == BW_IDLE || done)) begin
      phase_d = BW_SETUP;
      data_d  = data;
      rs_d    = rs;
      long_d  = long_wait;
    end
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_en   = en_q;

endmodule

// File: rtl/lcd_string_refresher.sv
// Powers up and initialises a 16x2 HD44780-class LCD in 8-bit mode, then paints
// both lines from the combinational string lookup, repainting whenever the
// feeder state code changes or a refresh is requested.
// Ports: iCLK/iRST_N clock and async active-low reset; iSTATE_CODE feeder
// state; iREFRESH refresh request; oINDEX/iCHAR string lookup handshake;
// LCD_DATA/LCD_RS/LCD_RW/LCD_EN panel pins; oBUSY init/paint in progress;
// oDONE one-cycle pulse at the end of each full paint.
module lcd_string_refresher
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC = 750000,
  parameter int unsigned EN_CYC    = 25,
  parameter int unsigned WAIT_CYC  = 2000,
  parameter int unsigned CLR_CYC   = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [4:0] iSTATE_CODE,
  input  logic       iREFRESH,
  output logic [4:0] oINDEX,
  input  logic [7:0] iCHAR,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       oBUSY,
  output logic       oDONE
);

  localparam int PW = $clog2(PWRUP_CYC + 1);

  main_state_e   state_q, state_d;
  logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [1:0]    init_q, init_d;
  logic [4:0]    idx_q, idx_d;
  logic [4:0]    code_q, code_d;
  logic          inflight_q, inflight_d;
  logic          tail_q, tail_d;
  logic          pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          start, wr_rs, wr_long, wr_done, ready;
  logic [7:0]    wr_data;

  lcd_bus_writer #(
    .EN_CYC  (EN_CYC),
    .WAIT_CYC(WAIT_CYC),
    .CLR_CYC (CLR_CYC)
  ) u_writer (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .start    (start),
    .rs       (wr_rs),
    .data     (wr_data),
    .long_wait(wr_long),
    .done     (wr_done),
    .lcd_data (LCD_DATA),
    .lcd_rs   (LCD_RS),
    .lcd_en   (LCD_EN)
  );

  // Writer can take a new transfer when nothing is in flight or in the
  // cycle the current one finishes.
  assign ready = !inflight_q || wr_done;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_PWRUP;
      pwr_cnt_q  <= PW'(PWRUP_CYC - 1);
      init_q     <= 2'd0;
      idx_q      <= 5'd0;
      code_q     <= 5'd0;
      inflight_q <= 1'b0;
      tail_q     <= 1'b0;
      pend_q     <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      init_q     <= init_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      inflight_q <= inflight_d;
      tail_q     <= tail_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    init_d     = init_q;
    idx_d      = idx_q;
    code_d     = code_q;
    tail_d     = tail_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    start      = 1'b0;
    wr_rs      = 1'b0;
    wr_data    = 8'h00;
    wr_long    = 1'b0;
    inflight_d = inflight_q && !wr_done;
    pend_d     = pend_q || iREFRESH || (iSTATE_CODE != code_q);
    case (state_q)
      ST_PWRUP: begin
        if (pwr_cnt_q == '0) state_d = ST_INIT;
        else                 pwr_cnt_d = pwr_cnt_q - 1'b1;
      end
      ST_INIT: begin
        wr_data = init_cmd(init_q);
        wr_long = (wr_data == LCD_CLEAR);
        if (ready) begin
          start  = 1'b1;
          init_d = init_q + 2'd1;
          // Every paint, including the first, consumes the pending flag and
          // snapshots the state code as it heads into ADDR1.
          if (init_q == 2'd3) begin
            state_d = ST_ADDR1;
            pend_d  = iREFRESH;
            code_d  = iSTATE_CODE;
          end
        end
      end
      ST_ADDR1: begin
        wr_data = LCD_LINE1;
        if (ready) begin
          start   = 1'b1;
          idx_d   = 5'h00;
          state_d = ST_LINE1;
        end
      end
      ST_LINE1: begin
        wr_rs   = 1'b1;
        wr_data = iCHAR;
        // oINDEX advances as each character launches, so the next lookup has
        // the whole transfer time to settle.
        if (ready) begin
          start = 1'b1;
          if (idx_q[3:0] == 4'hF) begin
            idx_d   = 5'h10;
            state_d = ST_ADDR2;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_ADDR2: begin
        wr_data = LCD_LINE2;
        if (ready) begin
          start   = 1'b1;
          state_d = ST_LINE2;
        end
      end
      ST_LINE2: begin
        wr_rs   = 1'b1;
        wr_data = iCHAR;
        // tail_q: last character launched, waiting for it to finish.
        if (!tail_q) begin
          if (ready) begin
            start = 1'b1;
            if (idx_q[3:0] == 4'hF) tail_d = 1'b1;
            else                    idx_d  = idx_q + 5'd1;
          end
        end else if (wr_done) begin
          tail_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pend_q) begin
          pend_d  = iREFRESH;
          code_d  = iSTATE_CODE;
          busy_d  = 1'b1;
          state_d = ST_ADDR1;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
    if (start) inflight_d = 1'b1;
  end

  assign oINDEX = idx_q;
  assign LCD_RW = 1'b0;
  assign oBUSY  = busy_q;
  assign oDONE  = done_q;

endmodule
